pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. Each cycle it decides whether each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) advances, holds or loads a bubble, and whether the PC updates. It handles four cases: load-use stalls, taken-branch flushes, multi-cycle data-memory waits and a drain-then-halt sequence. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 16, width of the performance counters
- MEM_TIMEOUT, 255, maximum number of MEM_WAIT cycles before MemErr is raised
- Clk  in  1  single clock, all state updates on posedge
- Rst  in  1  synchronous, active-high reset
- IDrs  in  5  source register rs of the instruction in ID
- IDrt  in  5  source register rt of the instruction in ID
- IDUsesRt  in  1  the ID instruction reads rt
- IDHalt  in  1  the ID instruction is HALT
- EXMemRead  in  1  the EX instruction is a load
- EXrt  in  5  destination register of the EX load
- BranchTaken  in  1  EX resolved a taken branch or jump
- MemReq  in  1  the MEM instruction accesses data memory
- MemReady  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC loads its next value
- IFIDEn, IDEXEn, EXMEMEn, MEMWBEn  out  1 each  register captures its input
- IFIDFlush, IDEXFlush, EXMEMFlush  out  1 each  register captures all-zero (bubble); only meaningful with the matching En=1
- Halted  out  1  pipeline drained and stopped
- MemErr  out  1  sticky memory-timeout flag
- StallCnt  out  CNT_W  stall cycles, saturating
- FlushCnt  out  CNT_W  branch flush events, saturating

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Outputs are combinational from the current state and inputs (Mealy). State, counters, the drain counter, the wait counter and MemErr are registered.
- Default in RUN: all En=1, all Flush=0, PCWrite=1.
- Priority in RUN, highest first: memory wait, branch, load-use, halt.
- **Memory wait**: MemReq && !MemReady.
  - All En=0, PCWrite=0, so every stage freezes in the same cycle.
  - Next state is MEM_WAIT and the wait counter is cleared.
- **MEM_WAIT**:
  - While MemReady=0: the freeze holds, StallCnt increments and the wait counter increments.
  - When the wait counter reaches MEM_TIMEOUT, MemErr sets. MemErr stays set until Rst.
  - The first cycle with MemReady=1 uses RUN rules for this cycle's outputs, and next state is RUN.
- **Branch**: BranchTaken=1.
  - IFIDFlush=1 and IDEXFlush=1, with their En=1.
  - PCWrite=1 so the PC loads the target.
  - FlushCnt increments.
  - Load-use and IDHalt are ignored this cycle, because both ID and IF are squashed.
- **Load-use hazard**: EXMemRead && EXrt!=0 && (EXrt==IDrs || (IDUsesRt && EXrt==IDrt)).
  - PCWrite=0, IFIDEn=0 (hold).
  - IDEXEn=1 with IDEXFlush=1 (insert bubble).
  - EXMEMEn=1, MEMWBEn=1.
  - StallCnt increments.
  - Exactly one stall cycle: the bubble clears the condition on the next cycle.
- **Halt**: IDHalt=1 with no higher-priority event.
  - PCWrite=0 and IFIDFlush=1.
  - Next state is DRAIN with the drain counter set to 3.
- **DRAIN**:
  - PCWrite=0, IFIDEn=0; downstream registers advance normally, including MEM_WAIT freezes.
  - The drain counter decrements only on cycles where the pipeline advances.
  - When it reaches 0, next state is HALTED.
- **HALTED**: all En=0, Halted=1. Only Rst leaves this state.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset, for the cycle Rst is sampled high:
  - state RUN; StallCnt=0, FlushCnt=0, MemErr=0, drain counter 0, wait counter 0.
  - While Rst=1, outputs are PCWrite=0, all En=1, all Flush=1, MEMWBEn=0, Halted=0, so every register loads a bubble.
- Rst asserted mid-MEM_WAIT or mid-DRAIN aborts the sequence; the next cycle is in RUN.
- Zero-latency decisions: a hazard present in cycle N controls the register captures at the end of cycle N.
- Branch and memory wait in the same cycle:
  - The freeze wins and FlushCnt does not increment.
  - BranchTaken is held by the frozen EX stage, so the flush happens in the cycle MemReady arrives.
- Load-use with EXrt==0: no stall.
- MemReady=1 together with MemReq=1 in RUN: no wait state.

## Test plan
- Load-use: EXMemRead=1, EXrt=5, IDrs=5 for one cycle -> PCWrite=0, IFIDEn=0, IDEXFlush=1, StallCnt 0->1; with EXrt=0 -> no stall.
- Branch: BranchTaken=1 with IDHalt=1 in the same cycle -> IFIDFlush=IDEXFlush=1, PCWrite=1, FlushCnt=1, state stays RUN.
- Memory wait: MemReq=1, MemReady=0 for 4 cycles, then 1 -> all En=0 for 4 cycles, StallCnt=4, normal advance on the fifth cycle.
- Timeout: MEM_TIMEOUT=3, MemReady held 0 -> MemErr=1 after 3 wait cycles; it stays 1 after MemReady, and clears only on Rst.
- Halt: IDHalt=1 with no hazards -> 3 advancing DRAIN cycles then Halted=1 and all En=0. A memory wait inserted during DRAIN extends it by the wait length.
- Saturation and reset: CNT_W=4, 20 load-use stalls -> StallCnt=15. Rst pulse mid-MEM_WAIT -> counters 0 and state RUN on the next cycle.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: per-cycle advance/hold/bubble
// decisions for each pipeline register, PC update control, and stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IDrs,
  input  logic [4:0]       IDrt,
  input  logic             IDUsesRt,
  input  logic             IDHalt,
  input  logic             EXMemRead,
  input  logic [4:0]       EXrt,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDEn,
  output logic             IDEXEn,
  output logic             EXMEMEn,
  output logic             MEMWBEn,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic             Halted,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             stall_inc, flush_inc, wait_tick;
  logic             mem_busy, load_use;

  assign mem_busy = MemReq && !MemReady;
  assign load_use = EXMemRead && (EXrt != 5'd0) &&
                    ((EXrt == IDrs) || (IDUsesRt && (EXrt == IDrt)));

  always_comb begin
    PCWrite    = 1'b1;
    IFIDEn     = 1'b1;
    IDEXEn     = 1'b1;
    EXMEMEn    = 1'b1;
    MEMWBEn    = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    Halted     = 1'b0;
    state_d    = state_q;
    drain_d    = drain_q;
    wait_d     = wait_q;
    err_d      = err_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    wait_tick  = 1'b0;

    unique case (state_q)
      StRun, StMemWait: begin
        if ((state_q == StMemWait) && !MemReady) begin
          {PCWrite, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn} = '0;
          stall_inc = 1'b1;
          wait_tick = 1'b1;
        end else begin
          state_d = StRun;
          if (mem_busy) begin
            {PCWrite, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn} = '0;
            stall_inc = 1'b1;
            state_d   = StMemWait;
            wait_d    = '0;
          end else if (BranchTaken) begin
            // ID and IF are squashed, so any hazard or HALT seen there is moot.
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            flush_inc = 1'b1;
          end else if (load_use) begin
            PCWrite   = 1'b0;
            IFIDEn    = 1'b0;
            IDEXFlush = 1'b1;
            stall_inc = 1'b1;
          end else if (IDHalt) begin
            PCWrite   = 1'b0;
            IFIDFlush = 1'b1;
            state_d   = StDrain;
            drain_d   = 2'd3;
          end
        end
      end
      StDrain: begin
        PCWrite = 1'b0;
        IFIDEn  = 1'b0;
        if (mem_busy) begin
          {IDEXEn, EXMEMEn, MEMWBEn} = '0;
          stall_inc = 1'b1;
          wait_tick = 1'b1;
        end else begin
          wait_d  = '0;
          drain_d = (drain_q == 2'd0) ? 2'd0 : drain_q - 2'd1;
          if (drain_q <= 2'd1) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        {PCWrite, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn} = '0;
        Halted = 1'b1;
      end
      default: state_d = StRun;
    endcase

    if (wait_tick) begin
      wait_d = (wait_q == TimeoutVal) ? wait_q : wait_q + WaitW'(1);
      if (wait_d == TimeoutVal) begin
        err_d = 1'b1;
      end
    end

    stall_d = (stall_inc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (flush_inc && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;

    // Under reset every register loads a bubble and nothing reaches write-back.
    if (Rst) begin
      PCWrite    = 1'b0;
      IFIDEn     = 1'b1;
      IDEXEn     = 1'b1;
      EXMEMEn    = 1'b1;
      MEMWBEn    = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
      EXMEMFlush = 1'b1;
      Halted     = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StRun;
      drain_q <= 2'd0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign MemErr   = err_q;
  assign StallCnt = stall_q;
  assign FlushCnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each driven cycle queues its expected controls and
// counters, and a negedge consumer compares them against the DUT.
module tb_pipeline_ctrl;

  localparam int unsigned CntW = 4;

  // {PCWrite, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn, IFIDFlush, IDEXFlush, EXMEMFlush, Halted}
  localparam logic [8:0] CRst  = 9'b0_1110_111_0;
  localparam logic [8:0] CAdv  = 9'b1_1111_000_0;
  localparam logic [8:0] CFrz  = 9'b0_0000_000_0;
  localparam logic [8:0] CBr   = 9'b1_1111_110_0;
  localparam logic [8:0] CLu   = 9'b0_0111_010_0;
  localparam logic [8:0] CHlt  = 9'b0_1111_100_0;
  localparam logic [8:0] CDrn  = 9'b0_0111_000_0;
  localparam logic [8:0] CHltd = 9'b0_0000_000_1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       halt;
    logic       exmr;
    logic [4:0] exrt;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct {
    string           tag;
    logic [8:0]      ctrl;
    logic [CntW-1:0] stall;
    logic [CntW-1:0] flush;
    logic            err;
  } exp_t;

  logic            clk = 1'b0;
  in_t             cur;
  logic            pc_write, ifid_en, idex_en, exmem_en, memwb_en;
  logic            ifid_flush, idex_flush, exmem_flush, halted, mem_err;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic [8:0]      obs_ctrl;

  exp_t            sb[$];
  logic [CntW-1:0] m_stall, m_flush;
  int              n_cmp = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .CNT_W      (CntW),
    .MEM_TIMEOUT(3)
  ) u_dut (
    .Clk        (clk),
    .Rst        (cur.rst),
    .IDrs       (cur.rs),
    .IDrt       (cur.rt),
    .IDUsesRt   (cur.uses_rt),
    .IDHalt     (cur.halt),
    .EXMemRead  (cur.exmr),
    .EXrt       (cur.exrt),
    .BranchTaken(cur.br),
    .MemReq     (cur.mreq),
    .MemReady   (cur.mrdy),
    .PCWrite    (pc_write),
    .IFIDEn     (ifid_en),
    .IDEXEn     (idex_en),
    .EXMEMEn    (exmem_en),
    .MEMWBEn    (memwb_en),
    .IFIDFlush  (ifid_flush),
    .IDEXFlush  (idex_flush),
    .EXMEMFlush (exmem_flush),
    .Halted     (halted),
    .MemErr     (mem_err),
    .StallCnt   (stall_cnt),
    .FlushCnt   (flush_cnt)
  );

  assign obs_ctrl = {pc_write, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic in_t f_idle();
    in_t p;
    p = '0;
    return p;
  endfunction

  function automatic in_t f_rst();
    in_t p;
    p     = '0;
    p.rst = 1'b1;
    return p;
  endfunction

  function automatic in_t f_lu(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                               input logic [4:0] exrt);
    in_t p;
    p         = '0;
    p.rs      = rs;
    p.rt      = rt;
    p.uses_rt = uses;
    p.exmr    = 1'b1;
    p.exrt    = exrt;
    return p;
  endfunction

  function automatic in_t f_mem(input logic rdy);
    in_t p;
    p      = '0;
    p.mreq = 1'b1;
    p.mrdy = rdy;
    return p;
  endfunction

  // Counters are registered, so this cycle sees the totals from previous cycles.
  task automatic drive(input string tag, input in_t in, input logic [8:0] ctrl, input bit st,
                       input bit fl, input logic err);
    exp_t e;
    cur     = in;
    e.tag   = tag;
    e.ctrl  = ctrl;
    e.stall = m_stall;
    e.flush = m_flush;
    e.err   = err;
    sb.push_back(e);
    if (in.rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (st && (m_stall != '1)) m_stall = m_stall + 1'b1;
      if (fl && (m_flush != '1)) m_flush = m_flush + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".ctrl"}, 32'(obs_ctrl), 32'(e.ctrl));
      check({e.tag, ".stall"}, 32'(stall_cnt), 32'(e.stall));
      check({e.tag, ".flush"}, 32'(flush_cnt), 32'(e.flush));
      check({e.tag, ".err"}, 32'(mem_err), 32'(e.err));
    end
  end

  initial begin
    in_t p;
    m_stall = '0;
    m_flush = '0;
    cur     = f_rst();
    @(posedge clk);
    #1;
    drive("rst", f_rst(), CRst, 0, 0, 0);
    drive("idle", f_idle(), CAdv, 0, 0, 0);

    drive("lu_rs", f_lu(5'd5, 5'd0, 1'b0, 5'd5), CLu, 1, 0, 0);
    drive("after_lu", f_idle(), CAdv, 0, 0, 0);
    drive("lu_rt", f_lu(5'd1, 5'd7, 1'b1, 5'd7), CLu, 1, 0, 0);
    drive("rt_unused", f_lu(5'd1, 5'd7, 1'b0, 5'd7), CAdv, 0, 0, 0);
    drive("exrt_zero", f_lu(5'd0, 5'd0, 1'b1, 5'd0), CAdv, 0, 0, 0);
    p      = f_lu(5'd5, 5'd5, 1'b1, 5'd5);
    p.exmr = 1'b0;
    drive("no_load", p, CAdv, 0, 0, 0);

    p      = f_lu(5'd5, 5'd0, 1'b0, 5'd5);
    p.br   = 1'b1;
    p.halt = 1'b1;
    drive("br_halt", p, CBr, 0, 1, 0);
    drive("post_br", f_idle(), CAdv, 0, 0, 0);

    // Entry cycle plus three MEM_WAIT cycles; the third wait cycle hits the timeout.
    for (int i = 0; i < 4; i++) drive($sformatf("mw%0d", i), f_mem(1'b0), CFrz, 1, 0, 0);
    drive("mw_rdy", f_mem(1'b1), CAdv, 0, 0, 1);
    drive("err_sticky", f_idle(), CAdv, 0, 0, 1);
    p    = f_mem(1'b0);
    p.br = 1'b1;
    drive("br_mw", p, CFrz, 1, 0, 1);
    p    = f_mem(1'b1);
    p.br = 1'b1;
    drive("br_rdy", p, CBr, 0, 1, 1);
    drive("rst_err", f_rst(), CRst, 0, 0, 1);
    drive("err_clr", f_idle(), CAdv, 0, 0, 0);

    drive("rmw0", f_mem(1'b0), CFrz, 1, 0, 0);
    drive("rmw1", f_mem(1'b0), CFrz, 1, 0, 0);
    drive("rst_mw", f_rst(), CRst, 0, 0, 0);
    drive("run_after_rst", f_idle(), CAdv, 0, 0, 0);

    p      = f_idle();
    p.halt = 1'b1;
    drive("halt", p, CHlt, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive($sformatf("drain%0d", i), f_idle(), CDrn, 0, 0, 0);
    drive("halted", f_idle(), CHltd, 0, 0, 0);
    p    = f_idle();
    p.br = 1'b1;
    drive("halted_br", p, CHltd, 0, 0, 0);
    drive("rst_h", f_rst(), CRst, 0, 0, 0);

    p      = f_idle();
    p.halt = 1'b1;
    drive("halt2", p, CHlt, 0, 0, 0);
    drive("d2_0", f_idle(), CDrn, 0, 0, 0);
    drive("d2_mw0", f_mem(1'b0), CFrz, 1, 0, 0);
    drive("d2_mw1", f_mem(1'b0), CFrz, 1, 0, 0);
    drive("d2_rdy", f_mem(1'b1), CDrn, 0, 0, 0);
    drive("d2_2", f_idle(), CDrn, 0, 0, 0);
    drive("halted2", f_idle(), CHltd, 0, 0, 0);
    drive("rst_s", f_rst(), CRst, 0, 0, 0);

    for (int i = 0; i < 20; i++) drive($sformatf("sat%0d", i), f_lu(5'd3, 5'd0, 1'b0, 5'd3), CLu,
                                       1, 0, 0);
    drive("sat_final", f_idle(), CAdv, 0, 0, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
